// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that owns the select lines of a 4:1 data mux.
//
// One requester at a time is granted. The grant is released when the granted
// requester drops its request, or after MAX_HOLD accepted transfers. Every
// release returns to IDLE for one cycle before the next grant. Priority starts
// at the requester after the one just released.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   req[3:0]   request per requester
//   i          requester data, requester k at [k*DW +: DW]
//   out_ready  downstream accepts the word when high together with out_valid
//   gnt[3:0]   registered one-hot grant, zero when idle
//   s[1:0]     registered mux select (index of the granted requester)
//   out_valid  selected word is valid (granted and still requesting)
//   out        selected word, zero when not valid
//   busy       high while a grant is held
module mux4_rr_arbiter #(
  parameter int unsigned DW       = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      req,
  input  logic [4*DW-1:0] i,
  input  logic            out_ready,
  output logic [3:0]      gnt,
  output logic [1:0]      s,
  output logic            out_valid,
  output logic [DW-1:0]   out,
  output logic            busy
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e          state_q, state_d;
  logic [3:0]      gnt_q, gnt_d;
  logic [1:0]      s_q, s_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [HW-1:0]   hold_q, hold_d;

  logic [1:0]      winner;
  logic [1:0]      idx;
  logic            found;
  logic            xfer;
  logic            last;

  // First requester found scanning ptr, ptr+1, ... modulo 4.
  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Output path depends only on registered state and live req/i, never on out_ready.
  always_comb begin
    busy      = (state_q == StGrant);
    out_valid = busy & req[s_q];
    out       = out_valid ? i[s_q*DW +: DW] : '0;
  end

  assign xfer = out_valid & out_ready;
  assign last = (hold_q == HW'(MAX_HOLD - 1));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    s_d     = s_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StGrant;
          gnt_d   = 4'b0001 << winner;
          s_d     = winner;
          hold_d  = '0;
        end
      end
      StGrant: begin
        if (!req[s_q] || (xfer && last)) begin
          // s keeps its last value; only the pointer moves on.
          state_d = StIdle;
          gnt_d   = '0;
          hold_d  = '0;
          ptr_d   = s_q + 2'd1;
        end else if (xfer) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      s_q     <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt = gnt_q;
  assign s   = s_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter (DW=8, MAX_HOLD=4).
// Stimulus pushes each expected transfer {index, word} into a queue; a monitor
// pops one entry per accepted word (out_valid && out_ready at the falling edge)
// and compares. Grant timing and idle gaps are checked inline by the stimulus.
module tb_mux4_rr_arbiter;

  localparam int unsigned DW = 8;

  logic          clk;
  logic          rst_n;
  logic [3:0]    req;
  logic [4*DW-1:0] i;
  logic          out_ready;
  logic [3:0]    gnt;
  logic [1:0]    s;
  logic          out_valid;
  logic [DW-1:0] out;
  logic          busy;

  int checks;
  int errors;

  logic [9:0] exp_q[$];  // {index[1:0], word[7:0]}

  localparam logic [31:0] IDATA = 32'h3CA5_1B0F;

  mux4_rr_arbiter #(
    .DW      (8),
    .MAX_HOLD(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .i        (i),
    .out_ready(out_ready),
    .gnt      (gnt),
    .s        (s),
    .out_valid(out_valid),
    .out      (out),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [7:0] word(input int k);
    logic [31:0] d;
    d = IDATA;
    return d[k*8 +: 8];
  endfunction

  task automatic push(input int k, input int n);
    for (int j = 0; j < n; j++) exp_q.push_back({2'(k), word(k)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string name);
    chk({name, ".gnt"}, 32'(gnt), 32'h0);
    chk({name, ".busy"}, 32'(busy), 32'h0);
    chk({name, ".valid"}, 32'(out_valid), 32'h0);
    chk({name, ".out"}, 32'(out), 32'h0);
  endtask

  task automatic chk_grant(input string name, input int k);
    chk({name, ".gnt"}, 32'(gnt), 32'(4'b0001 << k));
    chk({name, ".s"}, 32'(s), 32'(k));
    chk({name, ".busy"}, 32'(busy), 32'h1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Monitor: every accepted word must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL xfer.unexpected: got idx %0d word %0h, expected none", s, out);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        chk("xfer.word", 32'(out), 32'(e[7:0]));
        chk("xfer.idx", 32'(s), 32'(e[9:8]));
        chk("xfer.gnt", 32'(gnt), 32'(4'b0001 << e[9:8]));
      end
    end
  end

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    req       = 4'($urandom);
    i         = $urandom;
    out_ready = 1'($urandom);

    // Reset with random inputs, then release with req=0.
    #2;
    chk_idle("rst.during");
    chk("rst.s", 32'(s), 32'h0);
    tick();
    req = 4'b1111;
    i   = $urandom;
    #1;
    chk_idle("rst.during2");
    i   = IDATA;
    do_reset();
    chk_idle("rst.after");
    chk("rst.after.s", 32'(s), 32'h0);

    // Single requester: 4 transfers, release, one idle cycle, re-grant.
    req = 4'b0100;
    out_ready = 1'b1;
    push(2, 4);
    tick();
    chk_grant("single.g1", 2);
    chk("single.valid", 32'(out_valid), 32'h1);
    chk("single.out", 32'(out), 32'hA5);
    repeat (3) tick();
    chk("single.busy3", 32'(busy), 32'h1);
    tick();
    chk_idle("single.idle");
    tick();
    chk_grant("single.g2", 2);
    req = 4'b0000;
    #1;
    chk("single.drop.valid", 32'(out_valid), 32'h0);
    chk("single.drop.out", 32'(out), 32'h0);
    tick();
    chk_idle("single.rel");

    // Full contention: order 0,1,2,3,0 with 4 transfers each.
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      push(g % 4, 4);
      tick();
      chk_grant("cont.grant", g % 4);
      repeat (3) tick();
      chk("cont.busy", 32'(busy), 32'h1);
      tick();
      chk_idle("cont.idle");
      if (g == 4) req = 4'b0000;
    end
    tick();
    chk_idle("cont.end");

    // Backpressure: requester 1 stalled 3 cycles, then 4 transfers.
    do_reset();
    req       = 4'b0010;
    out_ready = 1'b0;
    tick();
    chk_grant("bp.grant", 1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_grant("bp.stall", 1);
      chk("bp.stall.valid", 32'(out_valid), 32'h1);
      chk("bp.stall.out", 32'(out), 32'h1B);
    end
    out_ready = 1'b1;
    push(1, 4);
    repeat (3) begin
      tick();
      chk("bp.busy", 32'(busy), 32'h1);
    end
    tick();
    chk_idle("bp.rel");
    req = 4'b0000;

    // Early drop: grant 0 briefly to move ptr to 1, then req=1011.
    do_reset();
    req = 4'b0001;
    tick();
    chk_grant("drop.pre", 0);
    req = 4'b0000;
    tick();
    chk_idle("drop.pre.rel");
    req = 4'b1011;
    push(1, 2);
    tick();
    chk_grant("drop.grant", 1);
    tick();
    tick();
    req = 4'b1001;
    #1;
    chk("drop.valid", 32'(out_valid), 32'h0);
    tick();
    chk_idle("drop.rel");
    tick();
    chk_grant("drop.next", 3);
    req = 4'b0000;
    tick();
    chk_idle("drop.end");

    // Reset mid-grant: requester 2 after 2 transfers, reset between edges.
    do_reset();
    req = 4'b0100;
    push(2, 2);
    tick();
    chk_grant("mid.grant", 2);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("mid.async");
    chk("mid.s", 32'(s), 32'h0);
    req = 4'b0110;
    tick();
    rst_n = 1'b1;
    tick();
    chk_grant("mid.regrant", 1);
    req = 4'b0000;
    tick();
    chk_idle("mid.end");

    tick();
    chk("queue.empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin controller that shares a 4:1 data mux between four requesters. It grants one requester at a time and drives the mux select from the grant. It presents the selected word on a valid/ready output port and releases the grant after the requester drops its request or after a bounded number of transfers. It sits directly in front of the 4:1 mux datapath and owns its select lines.

## Interface
- DW, 8, data width of each requester word and of the output.
- MAX_HOLD, 4, maximum transfers per grant (legal range ≥ 1).

- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request per requester; bit k = requester k.
- i  input  4*DW  requester data; requester k occupies bits [k*DW +: DW].
- out_ready  input  1  downstream accepts word when high with out_valid.
- gnt  output  4  registered one-hot grant (all-zero when idle).
- s  output  2  registered mux select = index of granted requester.
- out_valid  output  1  selected word is valid.
- out  output  DW  selected word.
- busy  output  1  high while in GRANT state.

## Operation
- Two states: IDLE, GRANT. Registers: state, gnt, s, ptr (2-bit priority pointer), hold_cnt (width clog2(MAX_HOLD+1)).
- IDLE:
  - If req ≠ 0, select the first set bit scanning ptr, ptr+1, … mod 4.
  - Next edge: gnt ← onehot(winner), s ← winner, hold_cnt ← 0, state ← GRANT.
  - If req = 0, stay in IDLE.
- GRANT:
  - out_valid = req[s].
  - out = i[s*DW +: DW] when out_valid, else 0.
  - A transfer occurs on an edge where out_valid && out_ready; hold_cnt increments.
- Release at an edge in GRANT when either:
  - (a) req[s] = 0 (no transfer that cycle), or
  - (b) a transfer occurs with hold_cnt = MAX_HOLD−1.
- On release: gnt ← 0, state ← IDLE, hold_cnt ← 0, ptr ← s+1 mod 4 (wraps 3→0). s holds its last value.
- req changes on non-granted lines during GRANT are ignored; no preemption.
- busy = (state == GRANT).

## Timing
- Reset (asynchronous, immediate) values:
  - gnt = 0, s = 0, ptr = 0, hold_cnt = 0, state = IDLE.
  - out_valid = 0, out = 0, busy = 0.
- Reset asserted mid-grant aborts the grant immediately. After deassertion, arbitration restarts from ptr = 0.
- Arbitration latency: requests seen in IDLE on edge n give gnt/s valid after edge n; out_valid can be high in the cycle following edge n.
- Back-to-back grants always have exactly one IDLE cycle between them. The same requester may be re-granted if it is the only one requesting.
- Backpressure (out_ready = 0) with req held: no transfer, hold_cnt unchanged, gnt/s/out stable.
- MAX_HOLD = 1: every transfer releases.
- out_valid/out are combinational from registered s and gnt state plus live req/i. There is no combinational path from out_ready to out_valid.

## Test plan
- Reset: drive rst_n=0 with random req/i.
  - Required: gnt=0, s=0, out_valid=0, out=0, busy=0, both during reset and after release with req=0.
- Single requester: req=4'b0100, i slice 2=8'hA5, out_ready=1, MAX_HOLD=4.
  - Required: gnt=4'b0100 and s=2 after first edge; out=8'hA5 valid for 4 cycles; release; 1 IDLE cycle; re-grant 4'b0100.
- Full contention: req=4'b1111 held, out_ready=1, MAX_HOLD=4.
  - Required: grant order 0,1,2,3,0; exactly 4 transfers each; one idle cycle between grants; ptr wraps 3→0.
- Backpressure: requester 1 granted; out_ready=0 for 3 cycles, then 1.
  - Required: gnt, s, out stable; hold_cnt frozen; 4 total transfers counted only on ready cycles.
- Early drop: req=4'b1011, requester 1 granted, req[1] cleared after 2 transfers.
  - Required: release on next edge; ptr=2; next grant goes to requester 3, not 0.
- Reset mid-grant: assert rst_n=0 while requester 2 holds the grant with hold_cnt=2.
  - Required: outputs clear without waiting for clk; after release with req=4'b0110, first grant goes to requester 1.
